// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl_if
// Brief    : Control, status and breakpoint bundle between a debug host and
//            the run controller.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_run_ctrl_if #(
    parameter int PC_WIDTH  = 10,
    parameter int CNT_WIDTH = 16,
    parameter int NUM_BP    = 2
);
    logic [1:0]                 mode_i;
    logic                       start_i;
    logic                       stop_i;
    logic                       step_i;
    logic [CNT_WIDTH-1:0]       run_len_i;
    logic [NUM_BP*PC_WIDTH-1:0] bp_addr_i;
    logic [NUM_BP-1:0]          bp_en_i;
    logic [PC_WIDTH-1:0]        pc_i;
    logic                       cpu_en_o;
    logic                       busy_o;
    logic                       done_o;
    logic [1:0]                 halt_cause_o;
    logic [NUM_BP-1:0]          bp_hit_o;
    logic [CNT_WIDTH-1:0]       cycle_cnt_o;

    modport master (
        output mode_i, start_i, stop_i, step_i, run_len_i, bp_addr_i, bp_en_i, pc_i,
        input  cpu_en_o, busy_o, done_o, halt_cause_o, bp_hit_o, cycle_cnt_o
    );

    modport slave (
        input  mode_i, start_i, stop_i, step_i, run_len_i, bp_addr_i, bp_en_i, pc_i,
        output cpu_en_o, busy_o, done_o, halt_cause_o, bp_hit_o, cycle_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Brief    : Run/debug controller gating a single-cycle CPU via clock-enable:
//            free run, run-N, single-step and run-to-breakpoint sessions.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int PC_WIDTH  = 10,
    parameter int CNT_WIDTH = 16,
    parameter int NUM_BP    = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    cpu_run_ctrl_if.slave     bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_STEP  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_RUNN   = 2'b01;
    localparam logic [1:0] MODE_STEP   = 2'b10;
    localparam logic [1:0] MODE_BP     = 2'b11;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_COUNT = 2'b01;
    localparam logic [1:0] CAUSE_BP    = 2'b10;
    localparam logic [1:0] CAUSE_STOP  = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [CNT_WIDTH-1:0] run_len_q, run_len_d;
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [1:0]           halt_cause_q, halt_cause_d;
    logic [NUM_BP-1:0]    bp_hit_q, bp_hit_d;
    logic                 done_q, done_d;

    logic [NUM_BP-1:0]    bp_match;
    logic                 bp_any;
    logic                 cnt_hit;
    logic                 halt_now;
    logic                 cpu_en;

    // Comparators are qualified by the latched mode so stale bp_en settings
    // cannot halt a session that is not a breakpoint session.
    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp_cmp
        assign bp_match[gi] = (mode_q == MODE_BP) && bus.bp_en_i[gi] &&
                              (bus.pc_i == bus.bp_addr_i[gi*PC_WIDTH +: PC_WIDTH]);
    end

    assign bp_any   = |bp_match;
    assign cnt_hit  = (mode_q == MODE_RUNN) && (cycle_cnt_q == run_len_q);
    assign halt_now = bus.stop_i || bp_any || cnt_hit;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        run_len_d    = run_len_q;
        cycle_cnt_d  = cycle_cnt_q;
        halt_cause_d = halt_cause_q;
        bp_hit_d     = bp_hit_q;
        cpu_en       = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start_i) begin
                    mode_d       = bus.mode_i;
                    run_len_d    = bus.run_len_i;
                    cycle_cnt_d  = CNT_ZERO;
                    halt_cause_d = CAUSE_NONE;
                    bp_hit_d     = '0;
                    state_d      = (bus.mode_i == MODE_STEP) ? ST_PAUSE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_now) begin
                    state_d = ST_HALT;
                    if (bus.stop_i) begin
                        halt_cause_d = CAUSE_STOP;
                    end else if (bp_any) begin
                        halt_cause_d = CAUSE_BP;
                        bp_hit_d     = bp_match;
                    end else begin
                        halt_cause_d = CAUSE_COUNT;
                    end
                end else begin
                    cpu_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (bus.stop_i) begin
                    state_d      = ST_HALT;
                    halt_cause_d = CAUSE_STOP;
                end else if (bus.step_i) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                cpu_en  = 1'b1;
                state_d = ST_PAUSE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter only advances in RUN/STEP, so it never collides with the
        // clear performed on start in IDLE/HALT.
        if (cpu_en && (cycle_cnt_q != CNT_MAX)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        end

        done_d = (state_d == ST_HALT) && (state_q != ST_HALT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'b00;
            run_len_q    <= CNT_ZERO;
            cycle_cnt_q  <= CNT_ZERO;
            halt_cause_q <= CAUSE_NONE;
            bp_hit_q     <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            run_len_q    <= run_len_d;
            cycle_cnt_q  <= cycle_cnt_d;
            halt_cause_q <= halt_cause_d;
            bp_hit_q     <= bp_hit_d;
            done_q       <= done_d;
        end
    end

    assign bus.cpu_en_o     = cpu_en;
    assign bus.busy_o       = (state_q == ST_RUN) || (state_q == ST_PAUSE) ||
                              (state_q == ST_STEP);
    assign bus.done_o       = done_q;
    assign bus.halt_cause_o = halt_cause_q;
    assign bus.bp_hit_o     = bp_hit_q;
    assign bus.cycle_cnt_o  = cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Brief    : Directed, table-driven bench for cpu_run_ctrl (CNT_WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int PW = 10;
    localparam int CW = 4;
    localparam int NB = 2;
    localparam int NV = 19;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    cpu_run_ctrl_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW), .NUM_BP(NB)) bus ();

    cpu_run_ctrl #(.PC_WIDTH(PW), .CNT_WIDTH(CW), .NUM_BP(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        start;
        logic        stop;
        logic        step;
        logic [3:0]  rlen;
        logic [9:0]  pc;
        logic [1:0]  bp_en;
        logic [9:0]  bp0;
        logic        e_en;
        logic        e_busy;
        logic        e_done;
        logic [1:0]  e_cause;
        logic [1:0]  e_hit;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vt [NV];

    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   en_cnt   = 0;
    int   done_cnt = 0;
    int   dbl      = 0;
    logic en_s     = 1'b0;
    logic prev_en  = 1'b0;

    function automatic int pk(logic en, logic busy, logic done, logic [1:0] cause,
                              logic [1:0] hit, logic [3:0] cnt);
        return int'({en, busy, done, cause, hit, cnt});
    endfunction

    function automatic int dut_pk();
        return pk(bus.cpu_en_o, bus.busy_o, bus.done_o, bus.halt_cause_o,
                  bus.bp_hit_o, bus.cycle_cnt_o);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, then return at posedge+1 with pulses
    // cleared and the bench CPU model's pc advanced if it was enabled.
    task automatic clk_step();
        @(negedge clk);
        en_s     = bus.cpu_en_o;
        en_cnt  += int'(en_s);
        done_cnt += int'(bus.done_o);
        if (en_s && prev_en) dbl++;
        prev_en  = en_s;
        @(posedge clk);
        #1;
        if (en_s) bus.pc_i = bus.pc_i + 10'd1;
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.step_i  = 1'b0;
    endtask

    task automatic run_n9(input string tag);
        bus.mode_i    = 2'b01;
        bus.run_len_i = 4'd9;
        bus.start_i   = 1'b1;
        en_cnt = 0; done_cnt = 0;
        clk_step();
        repeat (20) clk_step();
        check({tag, "_en_cycles"}, en_cnt, 9);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_cause"}, int'(bus.halt_cause_o), 1);
        check({tag, "_cnt"}, int'(bus.cycle_cnt_o), 9);
        check({tag, "_busy"}, int'(bus.busy_o), 0);
    endtask

    initial begin
        bus.mode_i    = 2'b00;
        bus.start_i   = 1'b0;
        bus.stop_i    = 1'b0;
        bus.step_i    = 1'b0;
        bus.run_len_i = 4'd0;
        bus.bp_addr_i = '0;
        bus.bp_en_i   = 2'b00;
        bus.pc_i      = 10'd0;

        //           mode  start stop  step  rlen  pc      bp_en  bp0     en    busy  done  cause hit    cnt
        vt[0]  = '{2'b00,1'b0,1'b0,1'b0,4'd0,10'd0,2'b00,10'd0, 1'b0,1'b0,1'b0,2'd0,2'b00,4'd0};
        vt[1]  = '{2'b00,1'b0,1'b1,1'b0,4'd0,10'd0,2'b00,10'd0, 1'b0,1'b0,1'b0,2'd0,2'b00,4'd0};
        vt[2]  = '{2'b00,1'b0,1'b0,1'b1,4'd0,10'd0,2'b00,10'd0, 1'b0,1'b0,1'b0,2'd0,2'b00,4'd0};
        vt[3]  = '{2'b01,1'b1,1'b0,1'b0,4'd2,10'd0,2'b00,10'd0, 1'b0,1'b0,1'b0,2'd0,2'b00,4'd0};
        vt[4]  = '{2'b00,1'b0,1'b0,1'b0,4'd0,10'd0,2'b00,10'd0, 1'b1,1'b1,1'b0,2'd0,2'b00,4'd0};
        vt[5]  = '{2'b00,1'b0,1'b0,1'b0,4'd0,10'd0,2'b00,10'd0, 1'b1,1'b1,1'b0,2'd0,2'b00,4'd1};
        vt[6]  = '{2'b00,1'b0,1'b0,1'b0,4'd0,10'd0,2'b00,10'd0, 1'b0,1'b1,1'b0,2'd0,2'b00,4'd2};
        vt[7]  = '{2'b00,1'b0,1'b0,1'b0,4'd0,10'd0,2'b00,10'd0, 1'b0,1'b0,1'b1,2'd1,2'b00,4'd2};
        vt[8]  = '{2'b00,1'b0,1'b0,1'b0,4'd0,10'd0,2'b00,10'd0, 1'b0,1'b0,1'b0,2'd1,2'b00,4'd2};
        vt[9]  = '{2'b01,1'b1,1'b0,1'b0,4'd0,10'd0,2'b00,10'd0, 1'b0,1'b0,1'b0,2'd1,2'b00,4'd2};
        vt[10] = '{2'b00,1'b0,1'b0,1'b0,4'd0,10'd0,2'b00,10'd0, 1'b0,1'b1,1'b0,2'd0,2'b00,4'd0};
        vt[11] = '{2'b00,1'b0,1'b0,1'b0,4'd0,10'd0,2'b00,10'd0, 1'b0,1'b0,1'b1,2'd1,2'b00,4'd0};
        vt[12] = '{2'b11,1'b1,1'b0,1'b0,4'd0,10'd5,2'b01,10'd5, 1'b0,1'b0,1'b0,2'd1,2'b00,4'd0};
        vt[13] = '{2'b11,1'b0,1'b0,1'b0,4'd0,10'd5,2'b01,10'd5, 1'b0,1'b1,1'b0,2'd0,2'b00,4'd0};
        vt[14] = '{2'b11,1'b0,1'b0,1'b0,4'd0,10'd5,2'b01,10'd5, 1'b0,1'b0,1'b1,2'd2,2'b01,4'd0};
        vt[15] = '{2'b11,1'b1,1'b0,1'b0,4'd0,10'd5,2'b01,10'd5, 1'b0,1'b0,1'b0,2'd2,2'b01,4'd0};
        vt[16] = '{2'b11,1'b0,1'b1,1'b0,4'd0,10'd5,2'b01,10'd5, 1'b0,1'b1,1'b0,2'd0,2'b00,4'd0};
        vt[17] = '{2'b11,1'b0,1'b0,1'b0,4'd0,10'd5,2'b01,10'd5, 1'b0,1'b0,1'b1,2'd3,2'b00,4'd0};
        vt[18] = '{2'b11,1'b0,1'b0,1'b1,4'd0,10'd5,2'b01,10'd5, 1'b0,1'b0,1'b0,2'd3,2'b00,4'd0};

        #2;
        check("reset_state", dut_pk(), pk(1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 4'd0));
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            bus.mode_i    = vt[i].mode;
            bus.start_i   = vt[i].start;
            bus.stop_i    = vt[i].stop;
            bus.step_i    = vt[i].step;
            bus.run_len_i = vt[i].rlen;
            bus.pc_i      = vt[i].pc;
            bus.bp_en_i   = vt[i].bp_en;
            bus.bp_addr_i = {10'h3FF, vt[i].bp0};
            @(negedge clk);
            check($sformatf("vec%0d", i), dut_pk(),
                  pk(vt[i].e_en, vt[i].e_busy, vt[i].e_done, vt[i].e_cause,
                     vt[i].e_hit, vt[i].e_cnt));
            @(posedge clk);
            #1;
        end
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.step_i  = 1'b0;

        // Mode 01, run_len 9
        run_n9("runn9");

        // Mode 11: pc walks 0..4, slot0 at 4; then re-hit, then slot1 at 7
        bus.pc_i      = 10'd0;
        bus.bp_addr_i = {10'd7, 10'd4};
        bus.bp_en_i   = 2'b11;
        bus.mode_i    = 2'b11;
        bus.start_i   = 1'b1;
        en_cnt = 0; done_cnt = 0;
        clk_step();
        repeat (15) clk_step();
        check("bp0_en_cycles", en_cnt, 4);
        check("bp0_pc", int'(bus.pc_i), 4);
        check("bp0_cause", int'(bus.halt_cause_o), 2);
        check("bp0_hit", int'(bus.bp_hit_o), 1);
        check("bp0_cnt", int'(bus.cycle_cnt_o), 4);
        check("bp0_done", done_cnt, 1);

        bus.start_i = 1'b1;
        en_cnt = 0; done_cnt = 0;
        clk_step();
        repeat (5) clk_step();
        check("rehit_en_cycles", en_cnt, 0);
        check("rehit_state", dut_pk(), pk(1'b0, 1'b0, 1'b0, 2'd2, 2'b01, 4'd0));
        check("rehit_done", done_cnt, 1);

        bus.bp_en_i = 2'b10;
        bus.start_i = 1'b1;
        en_cnt = 0; done_cnt = 0;
        clk_step();
        repeat (15) clk_step();
        check("bp1_en_cycles", en_cnt, 3);
        check("bp1_pc", int'(bus.pc_i), 7);
        check("bp1_state", dut_pk(), pk(1'b0, 1'b0, 1'b0, 2'd2, 2'b10, 4'd3));

        // Mode 10: three steps spaced 3 cycles, then stop+step together
        bus.bp_en_i = 2'b00;
        bus.mode_i  = 2'b10;
        bus.start_i = 1'b1;
        clk_step();
        en_cnt = 0; done_cnt = 0; dbl = 0; prev_en = 1'b0;
        check("pause_entry", dut_pk(), pk(1'b0, 1'b1, 1'b0, 2'd0, 2'b00, 4'd0));
        for (int k = 0; k < 3; k++) begin
            bus.step_i = 1'b1;
            clk_step();
            check($sformatf("step%0d_en", k), int'(bus.cpu_en_o), 1);
            clk_step();
            check($sformatf("step%0d_back", k), int'(bus.cpu_en_o), 0);
            clk_step();
        end
        check("step_pulses", en_cnt, 3);
        check("step_single", dbl, 0);
        check("step_cnt", int'(bus.cycle_cnt_o), 3);
        bus.stop_i = 1'b1;
        bus.step_i = 1'b1;
        clk_step();
        check("step_stop_halt", dut_pk(), pk(1'b0, 1'b0, 1'b1, 2'd3, 2'b00, 4'd3));
        repeat (2) clk_step();
        check("step_stop_cnt", int'(bus.cycle_cnt_o), 3);

        // Mode 00: saturation, start ignored while busy, stop timing
        bus.mode_i  = 2'b00;
        bus.start_i = 1'b1;
        en_cnt = 0;
        clk_step();
        repeat (10) clk_step();
        bus.mode_i    = 2'b01;
        bus.run_len_i = 4'd0;
        bus.start_i   = 1'b1;
        repeat (10) clk_step();
        check("free_en_cycles", en_cnt, 20);
        check("free_sat", dut_pk(), pk(1'b1, 1'b1, 1'b0, 2'd0, 2'b00, 4'd15));
        bus.stop_i = 1'b1;
        #1;
        check("stop_same_cycle", int'(bus.cpu_en_o), 0);
        clk_step();
        check("free_halt", dut_pk(), pk(1'b0, 1'b0, 1'b1, 2'd3, 2'b00, 4'd15));

        // Asynchronous reset mid-RUN, then a full run
        bus.mode_i    = 2'b01;
        bus.run_len_i = 4'd9;
        bus.start_i   = 1'b1;
        clk_step();
        repeat (4) clk_step();
        check("pre_reset_running", dut_pk(), pk(1'b1, 1'b1, 1'b0, 2'd0, 2'b00, 4'd4));
        #2 reset = 1'b0;
        #1;
        check("reset_async", dut_pk(), pk(1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 4'd0));
        done_cnt = 0;
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (5) clk_step();
        check("reset_no_done", done_cnt, 0);
        check("reset_idle", int'(bus.busy_o), 0);
        run_n9("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
